pipe_hazard_ctrl: RTL and testbench
===================================

# pipe_hazard_ctrl

Hazard and sequencing controller for the three-stage ID/EX/WB pipeline and its pipeline-register bank. It decides each cycle whether the PC and ID-stage registers hold, and whether a NOP bubble goes into EX. It redirects a taken branch or jump by squashing wrong-path instructions, selects the operand bypass source, and halts the core on a non-zero `tohost` write. It sits beside the pipeline-register bank and drives that bank's enable and clear controls.

## Interface
- `FLUSH_CYCLES`, default 2: bubbles inserted after the detect cycle of a redirect. This matches the two-register delay of the PC mux select. Legal range is 1..7.
- `CNT_W`, default 16: width of the saturating stall-cycle counter.

- `clk`  in  1  pipeline clock; all state updates on the rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `rs1_ID`, `rs2_ID`  in  5 each  source register addresses of the instruction in ID.
- `rs1_used_ID`, `rs2_used_ID`  in  1 each  the ID instruction reads that source.
- `rd_EX`  in  5  destination register of the EX instruction.
- `WrEn_RF_EX`  in  1  the EX instruction writes the register file.
- `is_load_EX`  in  1  the EX instruction is a data-memory load.
- `rd_WB`  in  5  destination register of the WB instruction.
- `WrEn_RF_WB`  in  1  the WB instruction writes the register file.
- `PC_Mux_EX`  in  1  the EX instruction redirects the PC (taken branch or jump).
- `csrw_EX`  in  1  the EX instruction is a csrw/csrwi to `tohost`.
- `csrw_result`  in  32  value being written to `tohost`.
- `stall_PC`  out  1  hold the PC.
- `stall_ID`  out  1  hold the ID-stage pipeline registers.
- `bubble_EX`  out  1  load a NOP into EX: forces WrEn_RF, WByteEn_DM and PC_Mux to 0 at the EX-register capture.
- `flush_ID`  out  1  invalidate the instruction currently in ID.
- `fwd1_sel`, `fwd2_sel`  out  2 each  operand bypass select: 00 = register file, 01 = EX result, 10 = WB result.
- `halted`  out  1  the core has halted.
- `stall_cycles`  out  CNT_W  saturating count of cycles in which `stall_PC` was 1.

## Operation
The state machine is registered. It has three states.
- **RUN**: normal operation.
- **FLUSH**: squashing wrong-path instructions.
- **HALT**: terminal until `reset`.

The down-counter `fcnt` is 3 bits wide.

**Hazard terms.** All are combinational from the inputs.
- `m1 = rs1_used_ID & rs1_ID!=0`; `m2` is the same for rs2.
- `hitEXn = mn & WrEn_RF_EX & rd_EX==rsn_ID`.
- `hitWBn = mn & WrEn_RF_WB & rd_WB==rsn_ID`.
- `load_use = is_load_EX & (hitEX1 | hitEX2)`.
- `redirect = PC_Mux_EX`.
- `halt_req = csrw_EX & csrw_result!=0`.

**Forwarding** is valid in every state.
- `fwdn_sel` = 01 if `hitEXn & !is_load_EX`.
- Otherwise 10 if `hitWBn`.
- Otherwise 00.
- The EX hit has priority over the WB hit. Register x0 never forwards.

**RUN**, priority high to low:
1. `halt_req`: `bubble_EX=1`, `flush_ID=1`, `stall_PC=1`. Next state is HALT.
2. `redirect`: `flush_ID=1`, `bubble_EX=1`. Load `fcnt=FLUSH_CYCLES`; next state is FLUSH.
3. `load_use`: `stall_PC=1`, `stall_ID=1`, `bubble_EX=1` for this cycle only. Stay in RUN. On the next cycle the load sits in WB and the operand forwards with sel 10.
4. Otherwise all control outputs are 0.

If `redirect` and `load_use` are both true, `redirect` wins and no stall is asserted.

**FLUSH**
- `flush_ID=1`, `bubble_EX=1`, `stall_PC=0`. `fcnt` decrements each cycle.
- `redirect`, `load_use` and `halt_req` are ignored, because EX holds only bubbles.
- When `fcnt` reaches 1, the next state is RUN.

**HALT**
- `stall_PC=1`, `stall_ID=1`, `bubble_EX=1`, `flush_ID=0`, `halted=1`.
- All inputs are ignored. The state exits only on `reset`.

**Stall counter.**
- `stall_cycles` increments on each clock edge where `stall_PC=1`, including HALT cycles.
- It saturates at all-ones.
- It is not cleared by leaving HALT, only by `reset`.

## Timing
- **Reset values.** State RUN, `fcnt=0`, `halted=0`, `stall_cycles=0`.
- **During reset.** While `reset` is high, `stall_PC`, `stall_ID`, `bubble_EX` and `flush_ID` are 0. `fwd*_sel` still follows its inputs.
- **Reset mid-FLUSH or in HALT.** The next cycle is RUN with no residual flush.
- **Output timing.** Stall, bubble and flush outputs are Mealy outputs, valid in the same cycle as the hazard inputs. They are consumed at the next rising edge.
- **Load-use latency.** Exactly one bubble per load-use hazard. Back-to-back load-use pairs each cost one cycle.
- **Redirect latency.** Detect cycle plus FLUSH_CYCLES cycles, so 3 flushed ID slots at the default. RUN resumes on cycle detect+FLUSH_CYCLES+1.
- **`halted` assertion.** `halted` rises on the edge after `halt_req` and is registered.

## Test plan
1. **ALU-to-ALU forward.** EX: add x5 (WrEn_RF_EX=1, rd_EX=5). ID: rs1_ID=5, rs1_used_ID=1. Required: `fwd1_sel`=01, no stall. With WB also writing x5: `fwd1_sel` still 01.
2. **Load-use stall.** EX: lw x7 (is_load_EX=1, rd_EX=7). ID: rs2_ID=7. Required:
   - Cycle 0: `stall_PC`=`stall_ID`=`bubble_EX`=1.
   - Cycle 1 (load in WB, rd_WB=7): stalls 0, `fwd2_sel`=10.
   - `stall_cycles`=1.
3. **x0 immunity.** rd_EX=0, rs1_ID=0, is_load_EX=1. Required: `fwd1_sel`=00, no stall.
4. **Redirect.** PC_Mux_EX=1 for one cycle. Required:
   - `flush_ID`=`bubble_EX`=1 for 3 consecutive cycles; a PC_Mux_EX pulse on cycle 2 is ignored.
   - RUN on cycle 3.
   - With FLUSH_CYCLES=1: 2 cycles.
5. **Halt.** csrw_EX=1 with csrw_result=1. Required: `halted`=1 next cycle; `stall_PC`=1 and `stall_cycles` increments every cycle thereafter. With csrw_result=0: no halt.
6. **Reset.** Assert `reset` asynchronously mid-FLUSH and in HALT. Required: all control outputs 0 immediately, `halted`=0, `stall_cycles`=0; normal RUN after release.

Source files
------------

// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the ID/EX/WB pipeline: load-use stalls,
// redirect squashing, operand bypass selection and tohost halt.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [4:0]       rs1_ID,
    input  logic [4:0]       rs2_ID,
    input  logic             rs1_used_ID,
    input  logic             rs2_used_ID,
    input  logic [4:0]       rd_EX,
    input  logic             WrEn_RF_EX,
    input  logic             is_load_EX,
    input  logic [4:0]       rd_WB,
    input  logic             WrEn_RF_WB,
    input  logic             PC_Mux_EX,
    input  logic             csrw_EX,
    input  logic [31:0]      csrw_result,
    output logic             stall_PC,
    output logic             stall_ID,
    output logic             bubble_EX,
    output logic             flush_ID,
    output logic [1:0]       fwd1_sel,
    output logic [1:0]       fwd2_sel,
    output logic             halted,
    output logic [CNT_W-1:0] stall_cycles
);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_FLUSH = 2'd1;
    localparam logic [1:0] S_HALT  = 2'd2;

    logic [1:0] state, state_nxt;
    logic [2:0] fcnt, fcnt_nxt;

    logic m1, m2;
    logic hit_ex1, hit_ex2, hit_wb1, hit_wb2;
    logic load_use, redirect, halt_req;

    assign m1       = rs1_used_ID & (rs1_ID != 5'd0);
    assign m2       = rs2_used_ID & (rs2_ID != 5'd0);
    assign hit_ex1  = m1 & WrEn_RF_EX & (rd_EX == rs1_ID);
    assign hit_ex2  = m2 & WrEn_RF_EX & (rd_EX == rs2_ID);
    assign hit_wb1  = m1 & WrEn_RF_WB & (rd_WB == rs1_ID);
    assign hit_wb2  = m2 & WrEn_RF_WB & (rd_WB == rs2_ID);
    assign load_use = is_load_EX & (hit_ex1 | hit_ex2);
    assign redirect = PC_Mux_EX;
    assign halt_req = csrw_EX & (csrw_result != 32'd0);

    // A load's data is not ready in EX, so only the WB copy may be bypassed.
    function automatic logic [1:0] fwd_sel(input logic hit_ex, input logic hit_wb,
                                           input logic is_load);
        if (hit_ex && !is_load) return 2'b01;
        else if (hit_wb)        return 2'b10;
        else                    return 2'b00;
    endfunction

    assign fwd1_sel = fwd_sel(hit_ex1, hit_wb1, is_load_EX);
    assign fwd2_sel = fwd_sel(hit_ex2, hit_wb2, is_load_EX);

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_nxt = state;
        fcnt_nxt  = fcnt;
        stall_PC  = 1'b0;
        stall_ID  = 1'b0;
        bubble_EX = 1'b0;
        flush_ID  = 1'b0;
        case (state)
            S_RUN: begin
                if (halt_req) begin
                    stall_PC  = 1'b1;
                    bubble_EX = 1'b1;
                    flush_ID  = 1'b1;
                    state_nxt = S_HALT;
                end else if (redirect) begin
                    bubble_EX = 1'b1;
                    flush_ID  = 1'b1;
                    fcnt_nxt  = 3'(FLUSH_CYCLES);
                    state_nxt = S_FLUSH;
                end else if (load_use) begin
                    stall_PC  = 1'b1;
                    stall_ID  = 1'b1;
                    bubble_EX = 1'b1;
                end
            end
            S_FLUSH: begin
                bubble_EX = 1'b1;
                flush_ID  = 1'b1;
                fcnt_nxt  = fcnt - 3'd1;
                if (fcnt <= 3'd1) state_nxt = S_RUN;
            end
            S_HALT: begin
                stall_PC  = 1'b1;
                stall_ID  = 1'b1;
                bubble_EX = 1'b1;
            end
            default: state_nxt = S_RUN;
        endcase
        // Pipeline-bank controls are quiet while reset is held.
        if (reset) begin
            stall_PC  = 1'b0;
            stall_ID  = 1'b0;
            bubble_EX = 1'b0;
            flush_ID  = 1'b0;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so all flops update together.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= S_RUN;
            fcnt         <= 3'd0;
            halted       <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state  <= state_nxt;
            fcnt   <= fcnt_nxt;
            halted <= (state_nxt == S_HALT);
            if (stall_PC && (stall_cycles != {CNT_W{1'b1}}))
                stall_cycles <= stall_cycles + 1'b1;
        end
    end

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed-vector bench for pipe_hazard_ctrl; a queue scoreboard decouples the
// driver from the negedge monitor. A second instance runs with FLUSH_CYCLES=1.
module tb_pipe_hazard_ctrl;

    typedef struct {
        logic        rst;
        logic [4:0]  rs1, rs2;
        logic        u1, u2;
        logic [4:0]  rd_ex;
        logic        we_ex, ld;
        logic [4:0]  rd_wb;
        logic        we_wb;
        logic        pcm;
        logic        csrw;
        logic [31:0] csr;
    } in_t;

    typedef struct packed {
        logic        spc, sid, bub, fid;
        logic [1:0]  f1, f2;
        logic        hlt;
        logic [15:0] cnt;
        logic        fid1;
    } obs_t;

    typedef struct {
        string name;
        obs_t  o;
    } sb_t;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [4:0]  rs1_ID = '0, rs2_ID = '0, rd_EX = '0, rd_WB = '0;
    logic        rs1_used_ID = 0, rs2_used_ID = 0, WrEn_RF_EX = 0, is_load_EX = 0;
    logic        WrEn_RF_WB = 0, PC_Mux_EX = 0, csrw_EX = 0;
    logic [31:0] csrw_result = '0;

    logic        stall_PC, stall_ID, bubble_EX, flush_ID, halted;
    logic [1:0]  fwd1_sel, fwd2_sel;
    logic [15:0] stall_cycles;
    logic        stall_PC1, stall_ID1, bubble_EX1, flush_ID1, halted1;
    logic [1:0]  fwd1_sel1, fwd2_sel1;
    logic [15:0] stall_cycles1;

    sb_t sb[$];
    int  vectors = 0;
    int  miscompares = 0;

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.FLUSH_CYCLES(2), .CNT_W(16)) u_dut (
        .clk(clk), .reset(reset),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .rd_EX(rd_EX), .WrEn_RF_EX(WrEn_RF_EX), .is_load_EX(is_load_EX),
        .rd_WB(rd_WB), .WrEn_RF_WB(WrEn_RF_WB),
        .PC_Mux_EX(PC_Mux_EX), .csrw_EX(csrw_EX), .csrw_result(csrw_result),
        .stall_PC(stall_PC), .stall_ID(stall_ID), .bubble_EX(bubble_EX),
        .flush_ID(flush_ID), .fwd1_sel(fwd1_sel), .fwd2_sel(fwd2_sel),
        .halted(halted), .stall_cycles(stall_cycles)
    );

    pipe_hazard_ctrl #(.FLUSH_CYCLES(1), .CNT_W(16)) u_dut1 (
        .clk(clk), .reset(reset),
        .rs1_ID(rs1_ID), .rs2_ID(rs2_ID),
        .rs1_used_ID(rs1_used_ID), .rs2_used_ID(rs2_used_ID),
        .rd_EX(rd_EX), .WrEn_RF_EX(WrEn_RF_EX), .is_load_EX(is_load_EX),
        .rd_WB(rd_WB), .WrEn_RF_WB(WrEn_RF_WB),
        .PC_Mux_EX(PC_Mux_EX), .csrw_EX(csrw_EX), .csrw_result(csrw_result),
        .stall_PC(stall_PC1), .stall_ID(stall_ID1), .bubble_EX(bubble_EX1),
        .flush_ID(flush_ID1), .fwd1_sel(fwd1_sel1), .fwd2_sel(fwd2_sel1),
        .halted(halted1), .stall_cycles(stall_cycles1)
    );

    function automatic in_t idle();
        in_t i;
        i = '{rst: 1'b0, rs1: 5'd0, rs2: 5'd0, u1: 1'b0, u2: 1'b0, rd_ex: 5'd0,
              we_ex: 1'b0, ld: 1'b0, rd_wb: 5'd0, we_wb: 1'b0, pcm: 1'b0,
              csrw: 1'b0, csr: 32'd0};
        return i;
    endfunction

    function automatic obs_t ob(input logic spc, input logic sid, input logic bub,
                                input logic fid, input logic [1:0] f1,
                                input logic [1:0] f2, input logic hlt,
                                input logic [15:0] cnt, input logic fid1);
        obs_t o;
        o = '{spc: spc, sid: sid, bub: bub, fid: fid, f1: f1, f2: f2,
              hlt: hlt, cnt: cnt, fid1: fid1};
        return o;
    endfunction

    // Inputs change 1 time unit after the rising edge; reset therefore lands
    // asynchronously in the middle of a cycle.
    task automatic vec(input string nm, input in_t i, input obs_t o);
        sb_t e;
        @(posedge clk);
        #1;
        reset       = i.rst;
        rs1_ID      = i.rs1;
        rs2_ID      = i.rs2;
        rs1_used_ID = i.u1;
        rs2_used_ID = i.u2;
        rd_EX       = i.rd_ex;
        WrEn_RF_EX  = i.we_ex;
        is_load_EX  = i.ld;
        rd_WB       = i.rd_wb;
        WrEn_RF_WB  = i.we_wb;
        PC_Mux_EX   = i.pcm;
        csrw_EX     = i.csrw;
        csrw_result = i.csr;
        e.name = nm;
        e.o    = o;
        sb.push_back(e);
    endtask

    task automatic check(input string nm, input obs_t act, input obs_t exp_o);
        vectors++;
        if (act !== exp_o) begin
            miscompares++;
            $display("FAIL %s: got spc=%b sid=%b bub=%b fid=%b f1=%b f2=%b hlt=%b cnt=%0d fid1=%b ; want spc=%b sid=%b bub=%b fid=%b f1=%b f2=%b hlt=%b cnt=%0d fid1=%b",
                     nm, act.spc, act.sid, act.bub, act.fid, act.f1, act.f2, act.hlt,
                     act.cnt, act.fid1, exp_o.spc, exp_o.sid, exp_o.bub, exp_o.fid,
                     exp_o.f1, exp_o.f2, exp_o.hlt, exp_o.cnt, exp_o.fid1);
        end
    endtask

    always @(negedge clk) begin
        if (sb.size() > 0) begin
            sb_t e;
            obs_t act;
            e = sb.pop_front();
            act = '{spc: stall_PC, sid: stall_ID, bub: bubble_EX, fid: flush_ID,
                    f1: fwd1_sel, f2: fwd2_sel, hlt: halted, cnt: stall_cycles,
                    fid1: flush_ID1};
            check(e.name, act, e.o);
        end
    end

    initial begin
        in_t i;

        // Reset state; bypass select still follows inputs during reset.
        i = idle(); i.rst = 1;
        vec("reset_state", i, ob(0,0,0,0, 2'b00,2'b00, 0, 0, 0));
        i.rs1 = 5; i.u1 = 1; i.we_ex = 1; i.rd_ex = 5;
        vec("reset_fwd", i, ob(0,0,0,0, 2'b01,2'b00, 0, 0, 0));

        // ALU-to-ALU forwarding and EX-over-WB priority.
        i = idle(); i.rs1 = 5; i.u1 = 1; i.we_ex = 1; i.rd_ex = 5;
        vec("fwd_ex", i, ob(0,0,0,0, 2'b01,2'b00, 0, 0, 0));
        i.we_wb = 1; i.rd_wb = 5;
        vec("fwd_ex_over_wb", i, ob(0,0,0,0, 2'b01,2'b00, 0, 0, 0));
        i = idle(); i.rs1 = 5; i.u1 = 1; i.rs2 = 5; i.u2 = 1; i.we_wb = 1; i.rd_wb = 5;
        vec("fwd_wb_both", i, ob(0,0,0,0, 2'b10,2'b10, 0, 0, 0));

        // Load-use: one bubble, then WB bypass.
        i = idle(); i.ld = 1; i.we_ex = 1; i.rd_ex = 7; i.rs2 = 7; i.u2 = 1;
        vec("load_use_stall", i, ob(1,1,1,0, 2'b00,2'b00, 0, 0, 0));
        i = idle(); i.we_wb = 1; i.rd_wb = 7; i.rs2 = 7; i.u2 = 1;
        vec("load_use_wb_fwd", i, ob(0,0,0,0, 2'b00,2'b10, 0, 1, 0));

        // x0 never forwards or stalls.
        i = idle(); i.ld = 1; i.we_ex = 1; i.rd_ex = 0; i.rs1 = 0; i.u1 = 1;
        vec("x0_immune", i, ob(0,0,0,0, 2'b00,2'b00, 0, 1, 0));

        // Back-to-back load-use pairs cost one cycle each.
        i = idle(); i.ld = 1; i.we_ex = 1; i.rd_ex = 3; i.rs1 = 3; i.u1 = 1;
        vec("b2b_load_use_a", i, ob(1,1,1,0, 2'b00,2'b00, 0, 1, 0));
        i.rd_ex = 4; i.rs1 = 4;
        vec("b2b_load_use_b", i, ob(1,1,1,0, 2'b00,2'b00, 0, 2, 0));
        i = idle();
        vec("after_b2b", i, ob(0,0,0,0, 2'b00,2'b00, 0, 3, 0));

        // Redirect beats a simultaneous load-use; FLUSH ignores halt and redirect.
        i = idle(); i.pcm = 1; i.ld = 1; i.we_ex = 1; i.rd_ex = 6; i.rs1 = 6; i.u1 = 1;
        vec("redir_detect", i, ob(0,0,1,1, 2'b00,2'b00, 0, 3, 1));
        i = idle(); i.csrw = 1; i.csr = 32'd5;
        vec("flush_1_halt_ign", i, ob(0,0,1,1, 2'b00,2'b00, 0, 3, 1));
        i = idle(); i.pcm = 1;
        vec("flush_2_redir_ign", i, ob(0,0,1,1, 2'b00,2'b00, 0, 3, 1));
        i = idle();
        vec("redir_resume", i, ob(0,0,0,0, 2'b00,2'b00, 0, 3, 1));
        vec("redir_idle", i, ob(0,0,0,0, 2'b00,2'b00, 0, 3, 0));

        // Halt: zero tohost write is not a halt.
        i = idle(); i.csrw = 1; i.csr = 32'd0;
        vec("csrw_zero", i, ob(0,0,0,0, 2'b00,2'b00, 0, 3, 0));
        i.csr = 32'd1;
        vec("halt_req", i, ob(1,0,1,1, 2'b00,2'b00, 0, 3, 1));
        i = idle();
        vec("halt_1", i, ob(1,1,1,0, 2'b00,2'b00, 1, 4, 0));
        i.pcm = 1; i.ld = 1; i.we_ex = 1; i.rd_ex = 6; i.rs1 = 6; i.u1 = 1;
        vec("halt_2_ign", i, ob(1,1,1,0, 2'b00,2'b00, 1, 5, 0));
        i = idle();
        vec("halt_3", i, ob(1,1,1,0, 2'b00,2'b00, 1, 6, 0));

        // Asynchronous reset in HALT.
        i = idle(); i.rst = 1;
        vec("reset_in_halt", i, ob(0,0,0,0, 2'b00,2'b00, 0, 0, 0));
        i = idle();
        vec("run_after_halt_rst", i, ob(0,0,0,0, 2'b00,2'b00, 0, 0, 0));

        // Asynchronous reset mid-FLUSH.
        i = idle(); i.pcm = 1;
        vec("redir2_detect", i, ob(0,0,1,1, 2'b00,2'b00, 0, 0, 1));
        i = idle();
        vec("redir2_flush", i, ob(0,0,1,1, 2'b00,2'b00, 0, 0, 1));
        i = idle(); i.rst = 1;
        vec("reset_mid_flush", i, ob(0,0,0,0, 2'b00,2'b00, 0, 0, 0));
        i = idle();
        vec("run_after_flush_rst", i, ob(0,0,0,0, 2'b00,2'b00, 0, 0, 0));

        // Normal operation after reset.
        i = idle(); i.ld = 1; i.we_ex = 1; i.rd_ex = 9; i.rs2 = 9; i.u2 = 1;
        vec("post_rst_load_use", i, ob(1,1,1,0, 2'b00,2'b00, 0, 0, 0));
        i = idle();
        vec("post_rst_count", i, ob(0,0,0,0, 2'b00,2'b00, 0, 1, 0));

        for (int k = 0; k < 10 && sb.size() > 0; k++) @(negedge clk);
        #1;
        if (sb.size() > 0) begin
            miscompares++;
            $display("FAIL drain_timeout: %0d vectors pending, want 0", sb.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
